// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_pkg: result-source, FSM state and counter definitions shared by   |
// | the write-back stage.                           Revision: 1.0        |
// +----------------------------------------------------------------------+
package wb_pkg;

  localparam int RETIRE_WIDTH = 16;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_IN   = 2'b10,
    WB_SWAP = 2'b11
  } wb_sel_e;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_SWAP2 = 1'b1
  } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/wb_result_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_result_mux: selects the register-file write data from the result  |
// | source and the SWAP phase.                      Revision: 1.0        |
// +----------------------------------------------------------------------+
module wb_result_mux
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [1:0]            sel,
  input  logic                  in_swap2,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] port_data,
  input  logic [DATA_WIDTH-1:0] swap_data,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = alu_result;
    if (in_swap2) begin
      result = swap_data;
    end else begin
      case (sel)
        WB_ALU:  result = alu_result;
        WB_MEM:  result = mem_data;
        WB_IN:   result = port_data;
        WB_SWAP: result = alu_result;
        default: result = alu_result;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_writeback_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_writeback_stage: MEM/WB register, SWAP serialisation FSM, write   |
// | port / forwarding outputs and retire counter.   Revision: 1.0        |
// +----------------------------------------------------------------------+
module wb_writeback_stage
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_wb_en,
  input  logic [1:0]               in_wb_sel,
  input  logic [ADDRESS_WIDTH-1:0] in_rdst,
  input  logic [ADDRESS_WIDTH-1:0] in_rsrc,
  input  logic [DATA_WIDTH-1:0]    in_alu_result,
  input  logic [DATA_WIDTH-1:0]    in_mem_data,
  input  logic [DATA_WIDTH-1:0]    in_port_data,
  input  logic [DATA_WIDTH-1:0]    in_swap_data,
  output logic                     stall,
  output logic                     write_enable,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic                     fwd_valid,
  output logic [ADDRESS_WIDTH-1:0] fwd_address,
  output logic [DATA_WIDTH-1:0]    fwd_data,
  output logic [RETIRE_WIDTH-1:0]  retire_count
);

  wb_state_e                 state_q, state_d;
  logic                      valid_q, valid_d;
  logic                      wb_en_q, wb_en_d;
  logic [1:0]                sel_q, sel_d;
  logic [ADDRESS_WIDTH-1:0]  rdst_q, rdst_d;
  logic [ADDRESS_WIDTH-1:0]  rsrc_q, rsrc_d;
  logic [DATA_WIDTH-1:0]     alu_q, alu_d;
  logic [DATA_WIDTH-1:0]     mem_q, mem_d;
  logic [DATA_WIDTH-1:0]     port_q, port_d;
  logic [DATA_WIDTH-1:0]     swap_q, swap_d;
  logic [RETIRE_WIDTH-1:0]   retire_q, retire_d;

  logic                      swap_start;
  logic                      in_swap2;
  logic                      retire_event;
  logic [DATA_WIDTH-1:0]     result;

  wb_result_mux #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_result_mux (
    .sel        (sel_q),
    .in_swap2   (in_swap2),
    .alu_result (alu_q),
    .mem_data   (mem_q),
    .port_data  (port_q),
    .swap_data  (swap_q),
    .result     (result)
  );

  always_comb begin
    in_swap2     = (state_q == ST_SWAP2);
    swap_start   = (state_q == ST_RUN) & valid_q & wb_en_q & (sel_q == WB_SWAP);
    retire_event = in_swap2 | ((state_q == ST_RUN) & valid_q & !swap_start);

    state_d = state_q;
    case (state_q)
      ST_RUN:   if (swap_start) state_d = ST_SWAP2;
      ST_SWAP2: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    // The slot is held only during the first SWAP cycle; SWAP2 frees it.
    valid_d = valid_q;
    wb_en_d = wb_en_q;
    sel_d   = sel_q;
    rdst_d  = rdst_q;
    rsrc_d  = rsrc_q;
    alu_d   = alu_q;
    mem_d   = mem_q;
    port_d  = port_q;
    swap_d  = swap_q;
    if (!swap_start) begin
      valid_d = in_valid;
      wb_en_d = in_wb_en;
      sel_d   = in_wb_sel;
      rdst_d  = in_rdst;
      rsrc_d  = in_rsrc;
      alu_d   = in_alu_result;
      mem_d   = in_mem_data;
      port_d  = in_port_data;
      swap_d  = in_swap_data;
    end

    retire_d = retire_event ? retire_q + RETIRE_WIDTH'(1) : retire_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      valid_q  <= 1'b0;
      wb_en_q  <= 1'b0;
      sel_q    <= '0;
      rdst_q   <= '0;
      rsrc_q   <= '0;
      alu_q    <= '0;
      mem_q    <= '0;
      port_q   <= '0;
      swap_q   <= '0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      wb_en_q  <= wb_en_d;
      sel_q    <= sel_d;
      rdst_q   <= rdst_d;
      rsrc_q   <= rsrc_d;
      alu_q    <= alu_d;
      mem_q    <= mem_d;
      port_q   <= port_d;
      swap_q   <= swap_d;
      retire_q <= retire_d;
    end
  end

  always_comb begin
    stall         = swap_start & !rst;
    write_enable  = !rst & (in_swap2 | (valid_q & wb_en_q));
    write_address = in_swap2 ? rsrc_q : rdst_q;
    write_data    = result;
    fwd_valid     = write_enable;
    fwd_address   = write_address;
    fwd_data      = write_data;
    retire_count  = retire_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_writeback_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_writeback_stage: scenario and randomized checks of the write-  |
// | back stage against a transaction-level model.   Revision: 1.0        |
// +----------------------------------------------------------------------+
module tb_wb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_wb_en;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_rdst, in_rsrc;
  logic [15:0] in_alu_result, in_mem_data, in_port_data, in_swap_data;
  logic        stall, write_enable, fwd_valid;
  logic [2:0]  write_address, fwd_address;
  logic [15:0] write_data, fwd_data, retire_count;

  always #5 clk = ~clk;

  wb_writeback_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_wb_en      (in_wb_en),
    .in_wb_sel     (in_wb_sel),
    .in_rdst       (in_rdst),
    .in_rsrc       (in_rsrc),
    .in_alu_result (in_alu_result),
    .in_mem_data   (in_mem_data),
    .in_port_data  (in_port_data),
    .in_swap_data  (in_swap_data),
    .stall         (stall),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .fwd_valid     (fwd_valid),
    .fwd_address   (fwd_address),
    .fwd_data      (fwd_data),
    .retire_count  (retire_count)
  );

  typedef struct {
    logic        valid;
    logic        wb_en;
    logic [1:0]  sel;
    logic [2:0]  rdst;
    logic [2:0]  rsrc;
    logic [15:0] alu;
    logic [15:0] mem;
    logic [15:0] port;
    logic [15:0] swap;
  } instr_t;

  // One entry per cycle of write-port activity the model expects.
  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        stall;
    logic        retire;
  } ev_t;

  ev_t         q[$];
  ev_t         cur;
  logic [15:0] exp_retire;
  logic [15:0] mreg[8];
  logic [15:0] dreg[8];
  int          total = 0;
  int          bad   = 0;

  // Register file fed by the DUT write port.
  always @(posedge clk) if (write_enable) dreg[write_address] <= write_data;

  function automatic instr_t mk(input logic v, input logic en, input logic [1:0] s,
                                input logic [2:0] rd, input logic [2:0] rs,
                                input logic [15:0] a, input logic [15:0] m,
                                input logic [15:0] p, input logic [15:0] w);
    instr_t i;
    i.valid = v; i.wb_en = en; i.sel = s; i.rdst = rd; i.rsrc = rs;
    i.alu = a; i.mem = m; i.port = p; i.swap = w;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    in_valid = i.valid; in_wb_en = i.wb_en; in_wb_sel = i.sel;
    in_rdst = i.rdst; in_rsrc = i.rsrc; in_alu_result = i.alu;
    in_mem_data = i.mem; in_port_data = i.port; in_swap_data = i.swap;
  endtask

  // Advance one clock edge and move the model along with it.
  task automatic tick();
    logic  acc;
    ev_t   e;
    acc = !cur.stall;
    @(posedge clk);
    if (rst) begin
      q.delete();
      cur = '{default: '0};
      exp_retire = 16'h0000;
    end else begin
      if (cur.we) mreg[cur.addr] = cur.data;
      exp_retire = exp_retire + 16'(cur.retire);
      if (acc) begin
        if (in_valid && in_wb_en && in_wb_sel == 2'b11) begin
          e = '{we: 1'b1, addr: in_rdst, data: in_alu_result, stall: 1'b1, retire: 1'b0};
          q.push_back(e);
          e = '{we: 1'b1, addr: in_rsrc, data: in_swap_data, stall: 1'b0, retire: 1'b1};
          q.push_back(e);
        end else begin
          e.we = in_valid & in_wb_en;
          e.addr = in_rdst;
          e.data = (in_wb_sel == 2'b01) ? in_mem_data :
                   (in_wb_sel == 2'b10) ? in_port_data : in_alu_result;
          e.stall = 1'b0;
          e.retire = in_valid;
          q.push_back(e);
        end
      end
      if (q.size() > 0) cur = q.pop_front();
      else cur = '{default: '0};
    end
    #1;
  endtask

  task automatic issue(input instr_t i);
    drive(i);
    tick();
  endtask

  task automatic idle();
    issue(mk(0, 0, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(mk(0, 0, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0));
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL reset_we: got %0b exp 0", write_enable); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b exp 0", stall); end
    total++; if (write_address !== 3'd0 || write_data !== 16'h0) begin bad++; $display("FAIL reset_port: got %0d/%h exp 0/0000", write_address, write_data); end
    total++; if (fwd_valid !== 1'b0 || fwd_address !== 3'd0 || fwd_data !== 16'h0) begin bad++; $display("FAIL reset_fwd: got %0b/%0d/%h exp 0/0/0000", fwd_valid, fwd_address, fwd_data); end
    total++; if (retire_count !== 16'h0) begin bad++; $display("FAIL reset_retire: got %h exp 0000", retire_count); end
  endtask

  task automatic test_alu();
    issue(mk(1, 1, 2'b00, 3'd3, 3'd0, 16'h1234, 16'h0, 16'h0, 16'h0));
    total++; if (write_enable !== 1'b1 || write_address !== 3'd3 || write_data !== 16'h1234) begin bad++; $display("FAIL alu_port: got %0b/%0d/%h exp 1/3/1234", write_enable, write_address, write_data); end
    idle();
    total++; if (dreg[3] !== 16'h1234) begin bad++; $display("FAIL alu_r3: got %h exp 1234", dreg[3]); end
    total++; if (retire_count !== 16'd1) begin bad++; $display("FAIL alu_retire: got %0d exp 1", retire_count); end
  endtask

  task automatic test_mem_in();
    issue(mk(1, 1, 2'b01, 3'd5, 3'd0, 16'h1111, 16'hBEEF, 16'h2222, 16'h3333));
    total++; if (stall !== 1'b0 || write_enable !== 1'b1 || write_address !== 3'd5 || write_data !== 16'hBEEF) begin bad++; $display("FAIL mem_port: got s%0b %0b/%0d/%h exp s0 1/5/beef", stall, write_enable, write_address, write_data); end
    issue(mk(1, 1, 2'b10, 3'd6, 3'd0, 16'h4444, 16'h5555, 16'h00FF, 16'h6666));
    total++; if (stall !== 1'b0 || write_enable !== 1'b1 || write_address !== 3'd6 || write_data !== 16'h00FF) begin bad++; $display("FAIL in_port: got s%0b %0b/%0d/%h exp s0 1/6/00ff", stall, write_enable, write_address, write_data); end
    idle();
    total++; if (dreg[5] !== 16'hBEEF || dreg[6] !== 16'h00FF) begin bad++; $display("FAIL mem_in_regs: got %h/%h exp beef/00ff", dreg[5], dreg[6]); end
  endtask

  task automatic test_swap();
    logic [15:0] r0;
    r0 = retire_count;
    issue(mk(1, 1, 2'b11, 3'd1, 3'd2, 16'hAAAA, 16'h0, 16'h0, 16'h5555));
    total++; if (stall !== 1'b1 || write_enable !== 1'b1 || write_address !== 3'd1 || write_data !== 16'hAAAA) begin bad++; $display("FAIL swap_c1: got s%0b %0b/%0d/%h exp s1 1/1/aaaa", stall, write_enable, write_address, write_data); end
    tick();
    total++; if (stall !== 1'b0 || write_enable !== 1'b1 || write_address !== 3'd2 || write_data !== 16'h5555) begin bad++; $display("FAIL swap_c2: got s%0b %0b/%0d/%h exp s0 1/2/5555", stall, write_enable, write_address, write_data); end
    issue(mk(1, 1, 2'b00, 3'd7, 3'd0, 16'h0777, 16'h0, 16'h0, 16'h0));
    total++; if (write_enable !== 1'b1 || write_address !== 3'd7 || write_data !== 16'h0777) begin bad++; $display("FAIL swap_next: got %0b/%0d/%h exp 1/7/0777", write_enable, write_address, write_data); end
    total++; if (retire_count !== r0 + 16'd1) begin bad++; $display("FAIL swap_retire: got %h exp %h", retire_count, r0 + 16'd1); end
    idle();
    total++; if (dreg[1] !== 16'hAAAA || dreg[2] !== 16'h5555 || dreg[7] !== 16'h0777) begin bad++; $display("FAIL swap_regs: got %h/%h/%h exp aaaa/5555/0777", dreg[1], dreg[2], dreg[7]); end
  endtask

  task automatic test_swap_same_store();
    logic [15:0] r0;
    issue(mk(1, 1, 2'b11, 3'd4, 3'd4, 16'hAAAA, 16'h0, 16'h0, 16'h5555));
    tick();
    idle();
    total++; if (dreg[4] !== 16'h5555) begin bad++; $display("FAIL swap_same_r4: got %h exp 5555", dreg[4]); end
    r0 = retire_count;
    issue(mk(1, 0, 2'b00, 3'd4, 3'd0, 16'h9999, 16'h0, 16'h0, 16'h0));
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL store_we: got %0b exp 0", write_enable); end
    idle();
    total++; if (dreg[4] !== 16'h5555 || retire_count !== r0 + 16'd1) begin bad++; $display("FAIL store_effect: got r4=%h cnt=%h exp 5555/%h", dreg[4], retire_count, r0 + 16'd1); end
  endtask

  task automatic test_reset_in_swap2();
    logic [15:0] old3;
    old3 = dreg[3];
    issue(mk(1, 1, 2'b11, 3'd2, 3'd3, 16'h1111, 16'h0, 16'h0, 16'h2222));
    tick();
    rst = 1'b1;
    drive(mk(0, 0, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0));
    #1;
    total++; if (write_enable !== 1'b0 || stall !== 1'b0 || fwd_valid !== 1'b0) begin bad++; $display("FAIL rst_swap2_forced: got we%0b s%0b fv%0b exp 000", write_enable, stall, fwd_valid); end
    tick();
    rst = 1'b0;
    total++; if (dreg[3] !== old3) begin bad++; $display("FAIL rst_swap2_r3: got %h exp %h", dreg[3], old3); end
    total++; if (write_enable !== 1'b0 || write_address !== 3'd0 || write_data !== 16'h0 || retire_count !== 16'h0) begin bad++; $display("FAIL rst_swap2_outs: got %0b/%0d/%h cnt=%h exp 0/0/0000 cnt=0000", write_enable, write_address, write_data, retire_count); end
    issue(mk(1, 1, 2'b00, 3'd0, 3'd0, 16'hCAFE, 16'h0, 16'h0, 16'h0));
    total++; if (stall !== 1'b0 || write_enable !== 1'b1 || write_data !== 16'hCAFE) begin bad++; $display("FAIL rst_swap2_run: got s%0b %0b/%h exp s0 1/cafe", stall, write_enable, write_data); end
    idle();
  endtask

  task automatic test_random();
    instr_t ins;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (!cur.stall) begin
        ins = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom));
        drive(ins);
      end
      tick();
      total++; if (write_enable !== cur.we || stall !== cur.stall) begin bad++; $display("FAIL rnd_ctl[%0d]: got we%0b s%0b exp we%0b s%0b", n, write_enable, stall, cur.we, cur.stall); end
      if (cur.we) begin
        total++; if (write_address !== cur.addr || write_data !== cur.data) begin bad++; $display("FAIL rnd_port[%0d]: got %0d/%h exp %0d/%h", n, write_address, write_data, cur.addr, cur.data); end
        total++; if (fwd_valid !== 1'b1 || fwd_address !== cur.addr || fwd_data !== cur.data) begin bad++; $display("FAIL rnd_fwd[%0d]: got %0b/%0d/%h exp 1/%0d/%h", n, fwd_valid, fwd_address, fwd_data, cur.addr, cur.data); end
      end
      total++; if (retire_count !== exp_retire) begin bad++; $display("FAIL rnd_retire[%0d]: got %h exp %h", n, retire_count, exp_retire); end
    end
    idle();
    idle();
    for (int r = 0; r < 8; r++) begin
      total++; if (dreg[r] !== mreg[r]) begin bad++; $display("FAIL rnd_reg[%0d]: got %h exp %h", r, dreg[r], mreg[r]); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(mk(1, 0, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0));
    for (int n = 0; n < 65536; n++) tick();
    total++; if (retire_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff: got %h exp ffff", retire_count); end
    tick();
    total++; if (retire_count !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %h exp 0000", retire_count); end
    total++; if (exp_retire !== 16'h0000) begin bad++; $display("FAIL wrap_model: got %h exp 0000", exp_retire); end
  endtask

  initial begin
    for (int r = 0; r < 8; r++) begin
      dreg[r] = 16'h0;
      mreg[r] = 16'h0;
    end
    cur = '{default: '0};
    exp_retire = 16'h0;
    rst = 1'b1;
    drive(mk(0, 0, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0));
    #1;
    test_reset();
    test_alu();
    test_mem_in();
    test_swap();
    test_swap_same_store();
    test_reset_in_swap2();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
